// File: rtl/inst_rom_pkg.sv
// rtl/inst_rom_pkg.sv - shared fetch-path constants and loader state encoding
package mips_defs;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_LOAD  = 1'b1
  } rom_state_t;

endpackage

// File: rtl/inst_rom_if.sv
// rtl/inst_rom_if.sv - fetch port and byte-serial program loader bundle
interface inst_rom_if #(
  parameter int DEPTH_LOG2 = 10
) ();

  logic                                   rom_ce;
  logic [mips_defs::INST_ADDR_WIDTH-1:0]  addr;
  logic [mips_defs::INST_WIDTH-1:0]       inst;
  logic                                   inst_valid;
  logic                                   addr_misaligned;
  logic                                   addr_out_of_range;

  logic                                   load_start;
  logic [7:0]                             load_byte;
  logic                                   load_byte_valid;
  logic                                   load_last;
  logic                                   load_busy;
  logic                                   load_done;
  logic                                   load_overflow;
  logic [DEPTH_LOG2:0]                    load_word_count;

  modport master (
    output rom_ce, addr, load_start, load_byte, load_byte_valid, load_last,
    input  inst, inst_valid, addr_misaligned, addr_out_of_range,
    input  load_busy, load_done, load_overflow, load_word_count
  );

  modport slave (
    input  rom_ce, addr, load_start, load_byte, load_byte_valid, load_last,
    output inst, inst_valid, addr_misaligned, addr_out_of_range,
    output load_busy, load_done, load_overflow, load_word_count
  );

endinterface

// File: rtl/inst_rom_byte_packer.sv
// rtl/inst_rom_byte_packer.sv - little-endian byte-to-word assembler for the loader
module rom_byte_packer
  import mips_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  input  logic                  load_last,
  output logic [INST_WIDTH-1:0] word,
  output logic                  word_valid
);

  logic [1:0]            lane_q;
  logic [INST_WIDTH-1:0] asm_q;
  logic [INST_WIDTH-1:0] merged;

  // The strobe is combinational so the word lands on the same edge as its last byte.
  always_comb begin
    merged = asm_q;
    merged[{lane_q, 3'b000} +: 8] = load_byte;
  end

  assign word       = merged;
  assign word_valid = load_byte_valid && ((lane_q == 2'd3) || load_last);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      lane_q <= 2'd0;
      asm_q  <= '0;
    end else if (load_byte_valid) begin
      if (word_valid) begin
        lane_q <= 2'd0;
        asm_q  <= '0;
      end else begin
        lane_q <= lane_q + 2'd1;
        asm_q  <= merged;
      end
    end
  end

endmodule

// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - instruction memory with registered fetch port and program loader
module inst_rom
  import mips_defs::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input logic       clk,
  input logic       rst,
  inst_rom_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  rom_state_t state_q;
  rom_state_t state_n;
  logic       done_n;

  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic                  overflow_q;
  logic                  done_q;

  logic [INST_WIDTH-1:0] inst_q;
  logic                  valid_q;
  logic                  mis_q;
  logic                  oor_q;

  logic                  byte_en;
  logic                  word_valid;
  logic [INST_WIDTH-1:0] word;
  logic                  ptr_full;
  logic                  fetch_en;
  logic                  addr_oor;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // A load_start restarts the loader, so a byte arriving with it is discarded.
  assign byte_en  = bus.load_byte_valid && (state_q == S_LOAD) && !bus.load_start;
  assign ptr_full = wr_ptr[DEPTH_LOG2];
  assign fetch_en = bus.rom_ce && (state_q == S_FETCH) && !bus.load_start;
  assign addr_oor = |bus.addr[INST_ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign rd_idx   = bus.addr[DEPTH_LOG2+1:2];

  rom_byte_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .flush           (bus.load_start),
    .load_byte       (bus.load_byte),
    .load_byte_valid (byte_en),
    .load_last       (bus.load_last),
    .word            (word),
    .word_valid      (word_valid)
  );

  always_comb begin
    state_n = state_q;
    done_n  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.load_start) state_n = S_LOAD;
      end
      S_LOAD: begin
        if (!bus.load_start && byte_en && bus.load_last) begin
          state_n = S_FETCH;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      done_q     <= 1'b0;
      wr_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_n;
      done_q  <= done_n;
      if (bus.load_start) begin
        wr_ptr     <= '0;
        overflow_q <= 1'b0;
      end else if (word_valid) begin
        if (ptr_full) overflow_q <= 1'b1;
        else          wr_ptr     <= wr_ptr + 1'b1;
      end
    end
  end

  // The array has no reset so a reboot keeps the loaded program.
  always_ff @(posedge clk) begin
    if (!rst && word_valid && !ptr_full) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else if (fetch_en) begin
      inst_q  <= addr_oor ? NOP_INST : mem[rd_idx];
      valid_q <= 1'b1;
      mis_q   <= |bus.addr[1:0];
      oor_q   <= addr_oor;
    end else begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
    end
  end

  assign bus.inst              = inst_q;
  assign bus.inst_valid        = valid_q;
  assign bus.addr_misaligned   = mis_q;
  assign bus.addr_out_of_range = oor_q;
  assign bus.load_busy         = (state_q == S_LOAD);
  assign bus.load_done         = done_q;
  assign bus.load_overflow     = overflow_q;
  assign bus.load_word_count   = wr_ptr;

endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction memory responder at the far end of the fetch interface: it takes the PC's fetch address and fetch-enable and returns one 32-bit instruction per cycle with a registered, one-cycle read latency. It also contains a byte-serial program loader, so the bench or a boot controller can fill the array before the core runs. It sits between `pc` and the IF/ID pipeline register.

## Interface
- `INST_ADDR_WIDTH`, 32, fetch byte-address width (shared constant)
- `INST_WIDTH`, 32, instruction word width (shared constant)
- `DEPTH_LOG2`, 10, log2 of array depth in words (1024 words = 4 KiB)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `rom_ce`  in  1  fetch enable, driven by the PC's `pc_enable`
- `addr`  in  INST_ADDR_WIDTH  fetch byte address
- `inst`  out  INST_WIDTH  fetched instruction
- `inst_valid`  out  1  `inst` holds a real fetch result
- `addr_misaligned`  out  1  registered flag: `addr[1:0]` was nonzero
- `addr_out_of_range`  out  1  registered flag: word index is at or beyond the array depth
- `load_start`  in  1  one-cycle pulse that begins a program load
- `load_byte`  in  8  load data byte
- `load_byte_valid`  in  1  `load_byte` is valid this cycle
- `load_last`  in  1  qualifies the final byte of the load; meaningful only with `load_byte_valid`
- `load_busy`  out  1  loader is active and fetch is blocked
- `load_done`  out  1  one-cycle pulse when a load completes
- `load_overflow`  out  1  sticky: a word was dropped because the array was full
- `load_word_count`  out  DEPTH_LOG2+1  number of words written by the current or last load

## Operation
- FSM with two states, `S_FETCH` (reset state) and `S_LOAD`.
- `S_FETCH`, `rom_ce`=1:
  - `inst` <= mem[`addr[DEPTH_LOG2+1:2]`], `inst_valid` <= 1.
  - Both flags are registered alongside `inst`.
- Misaligned address: the word at floor(addr/4) is still returned, with `addr_misaligned`=1.
- Out of range: any bit of `addr[INST_ADDR_WIDTH-1:DEPTH_LOG2+2]` is set. Then `inst` <= NOP (32'h0), `inst_valid` <= 1, `addr_out_of_range` <= 1.
- `S_FETCH`, `rom_ce`=0: `inst` <= NOP, `inst_valid` <= 0, both flags <= 0.
- `load_start` in `S_FETCH` moves the FSM to `S_LOAD` and clears the word pointer, `load_word_count` and `load_overflow`.
- `load_start` has priority over a simultaneous fetch: that cycle's fetch is dropped and `inst_valid` is 0 from the next cycle.
- `S_LOAD` byte packing:
  - Bytes pack little-endian: the first byte goes to `[7:0]`, the fourth to `[31:24]`.
  - Each completed word is written at the pointer, then the pointer and `load_word_count` increment.
- Overflow: when the pointer is already at depth, the word is dropped, `load_overflow` <= 1, and the count stops.
- `load_last` byte:
  - Any partial word is zero-padded in its upper bytes and written.
  - The FSM returns to `S_FETCH` and `load_done` pulses.
- `load_start` while in `S_LOAD`: restart. The partial word is discarded and the pointer and count clear.
- Fetch while in `S_LOAD`: `rom_ce` is ignored, `inst`=NOP, `inst_valid`=0.

## Timing
- Read latency is 1 cycle: address accepted at edge N, `inst` valid after edge N+1, sustaining one fetch per cycle.
- `load_busy` = (state == `S_LOAD`), combinational from the state register. It rises the cycle after the `load_start` edge.
- Final word write and state return occur on the same edge as the `load_last` byte. `load_done` is high for the following cycle only.
- The first fetch is accepted in the cycle after `load_done` rises, so there is no read-during-write hazard.
- Reset values:
  - `inst`=0, `inst_valid`=0, both address flags 0.
  - `load_busy`=0, `load_done`=0, `load_overflow`=0, `load_word_count`=0.
  - State `S_FETCH`, pointer 0, packer empty.
- Reset does not clear the memory array.
- Reset mid-load: the load is aborted, the partial word is discarded, and `load_done` is not pulsed. Words already written are kept.

## Structure
- Shared package `mips_defs`: `INST_ADDR_WIDTH`, `INST_WIDTH`, `NOP_INST`=32'h0, and the state encoding `S_FETCH`/`S_LOAD`.
- Sub-module `rom_byte_packer`:
  - Contains the byte-lane counter and the 32-bit assembly register.
  - Outputs a word plus a one-cycle `word_valid` strobe.
  - Inputs are `load_byte`, `load_byte_valid`, `load_last` and `flush`/clear.
- Top level holds the FSM, the write pointer, the registered read port and the flags.

## Test plan
- Load bytes 78 56 34 12 EF BE AD DE, with `load_last` on the 8th byte -> mem[0]=32'h12345678, mem[1]=32'hDEADBEEF; `load_done` pulses once; `load_word_count`=2.
- `rom_ce`=1 with `addr`=0,4,8 on consecutive cycles -> one cycle later `inst`=12345678, then DEADBEEF, then mem[2], with `inst_valid` held at 1.
- Partial-word load:
  - Load bytes AA BB CC, with `load_last` on CC -> mem[0]=32'h00CCBBAA; `load_word_count`=1.
  - Then fetch `addr`=32'h2 -> `inst`=00CCBBAA and `addr_misaligned`=1.
- Fetch `addr`=32'h1000 at default depth -> `inst`=0, `inst_valid`=1, `addr_out_of_range`=1.
- Load 1025 words -> `load_overflow`=1; `load_word_count`=1024; mem[0..1023] correct.
- Reset and conflict cases:
  - Assert `rst` after 2 bytes of a load -> `load_busy`=0 next cycle, no `load_done`, prior memory contents intact.
  - Assert `load_start` together with `rom_ce` -> `inst_valid`=0 on the next cycle.
